// File: rtl/rijndael_mixcolumns_iter.sv
// rijndael_mixcolumns_iter: iterative AES/Rijndael MixColumns engine.
// One column is transformed per clock through a single shared 4-byte
// datapath; a ready/valid handshake frames input and output.
// Optional macro RIJNDAEL_INV_MIXCOLUMNS_EN adds InvMixColumns support,
// selected per operation by in_inverse. Without it only the forward
// transform is built and in_inverse is ignored.
`default_nettype none

module rijndael_mixcolumns_iter #(
   parameter int NB = 4,
   localparam int STATESIZE = 32 * NB
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_inverse,
   input  logic [STATESIZE-1:0] in_state,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [STATESIZE-1:0] out_state
);

   localparam int CW = $clog2(NB);
   localparam logic [CW-1:0] LAST_COL = CW'(NB - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state_reg, state_next;
   logic [CW-1:0]        col_reg, col_next;
   logic [STATESIZE-1:0] work_reg, work_next;

   logic [31:0] cols [NB];
   logic [31:0] col_in;
   logic [31:0] col_out;
   logic [7:0]  a  [4];
   logic [7:0]  fw [4];

   // Multiply by x (0x02) in GF(2^8) modulo 0x11B.
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Split the working register into columns; column 0 sits at the MSBs.
   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_cols
         assign cols[gi] = work_reg[STATESIZE-1-32*gi -: 32];
      end
   endgenerate

   assign col_in = cols[col_reg];

   // Forward MixColumns: row r = 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3].
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
         assign a[gi]  = col_in[31-8*gi -: 8];
         assign fw[gi] = xt(a[gi]) ^ xt(a[(gi+1)%4]) ^ a[(gi+1)%4]
                       ^ a[(gi+2)%4] ^ a[(gi+3)%4];
      end
   endgenerate

`ifdef RIJNDAEL_INV_MIXCOLUMNS_EN
   logic       mode_reg, mode_next;
   logic [7:0] m2 [4];
   logic [7:0] m4 [4];
   logic [7:0] m8 [4];
   logic [7:0] iv [4];

   // Inverse MixColumns built from repeated doubling:
   // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_inv
         assign m2[gi] = xt(a[gi]);
         assign m4[gi] = xt(m2[gi]);
         assign m8[gi] = xt(m4[gi]);
         assign iv[gi] = (m8[gi] ^ m4[gi] ^ m2[gi])
                       ^ (m8[(gi+1)%4] ^ m2[(gi+1)%4] ^ a[(gi+1)%4])
                       ^ (m8[(gi+2)%4] ^ m4[(gi+2)%4] ^ a[(gi+2)%4])
                       ^ (m8[(gi+3)%4] ^ a[(gi+3)%4]);
      end
   endgenerate

   assign col_out = mode_reg ? {iv[0], iv[1], iv[2], iv[3]}
                             : {fw[0], fw[1], fw[2], fw[3]};

   // Mode is captured at accept and held for the whole operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mode_reg <= 1'b0;
      else        mode_reg <= mode_next;
   end

   // Next mode: sample in_inverse only on accept.
   always_comb begin
      mode_next = mode_reg;
      if (state_reg == IDLE && in_valid) mode_next = in_inverse;
   end
`else
   logic unused_inverse;
   assign unused_inverse = in_inverse;
   assign col_out = {fw[0], fw[1], fw[2], fw[3]};
`endif

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign out_state = work_reg;

   // State, column counter and working register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         col_reg   <= '0;
         work_reg  <= '0;
      end else begin
         state_reg <= state_next;
         col_reg   <= col_next;
         work_reg  <= work_next;
      end
   end

   // Next-state logic: accept in IDLE, one column per BUSY cycle, hold in DONE.
   always_comb begin
      state_next = state_reg;
      col_next   = col_reg;
      work_next  = work_reg;
      unique case (state_reg)
         IDLE: begin
            if (in_valid) begin
               work_next  = in_state;
               col_next   = '0;
               state_next = BUSY;
            end
         end
         BUSY: begin
            for (int i = 0; i < NB; i++) begin
               if (col_reg == CW'(i)) work_next[STATESIZE-1-32*i -: 32] = col_out;
            end
            if (col_reg == LAST_COL) state_next = DONE;
            else                     col_next   = col_reg + 1'b1;
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_rijndael_mixcolumns_iter.sv
// Bench for rijndael_mixcolumns_iter: directed vectors, back-pressure,
// mid-operation reset and random vectors against a GF(2^8) matrix model.
// Inverse expectations follow RIJNDAEL_INV_MIXCOLUMNS_EN.
module tb_rijndael_mixcolumns_iter;

`ifdef RIJNDAEL_INV_MIXCOLUMNS_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid, in_ready, in_inverse, out_valid, out_ready;
   logic [127:0] in_state, out_state;
   logic         in_valid8, in_ready8, in_inverse8, out_valid8, out_ready8;
   logic [255:0] in_state8, out_state8;

   int checks = 0;
   int failures = 0;

   rijndael_mixcolumns_iter #(.NB(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_inverse(in_inverse),
      .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
      .out_state(out_state)
   );

   rijndael_mixcolumns_iter #(.NB(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_inverse(in_inverse8),
      .in_state(in_state8), .out_valid(out_valid8), .out_ready(out_ready8),
      .out_state(out_state8)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Generic shift-and-add GF(2^8) multiply, polynomial 0x11B.
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (y[k]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   // Matrix product per column; coefficient depends on (c - r) mod 4.
   function automatic logic [255:0] mix_model(input logic [255:0] st, input int nb, input bit inv);
      logic [7:0]   fc [4];
      logic [7:0]   ic [4];
      logic [255:0] res = '0;
      logic [7:0]   acc;
      int           sz;
      fc = '{8'h02, 8'h03, 8'h01, 8'h01};
      ic = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      sz = 32 * nb;
      for (int i = 0; i < nb; i++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int c = 0; c < 4; c++)
               acc ^= gmul(inv ? ic[(c - r + 4) % 4] : fc[(c - r + 4) % 4],
                           st[sz-1-32*i-8*c -: 8]);
            res[sz-1-32*i-8*r -: 8] = acc;
         end
      end
      return res;
   endfunction

   // One NB=4 operation: accept, latency, optional stall, result, release.
   task automatic run4(input logic [127:0] st, input bit inv, input int stall,
                       input logic [127:0] exp, input string tag);
      int lat;
      check({tag, "_idle_ready"}, in_ready, 1);
      in_valid = 1'b1; in_state = st; in_inverse = inv; out_ready = 1'b0;
      @(negedge clk);
      // Garbage on the inputs while busy must not matter.
      in_valid = 1'($urandom_range(0, 1));
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_inverse = 1'($urandom_range(0, 1));
      lat = 0;
      while (!out_valid && lat < 12) begin
         check({tag, "_busy_ready"}, in_ready, 0);
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, 4);
      for (int s = 0; s < stall; s++) begin
         check({tag, "_stall_state"}, out_state, exp);
         check({tag, "_stall_valid"}, out_valid, 1);
         check({tag, "_stall_ready"}, in_ready, 0);
         @(negedge clk);
      end
      check({tag, "_result"}, out_state, exp);
      out_ready = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_release_valid"}, out_valid, 0);
      check({tag, "_release_ready"}, in_ready, 1);
      in_valid = 1'b0;
   endtask

   localparam logic [127:0] V29 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] E29 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] V30 = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
   localparam logic [127:0] E30 = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

   initial begin
      logic [127:0] st, e30, e34;
      logic [255:0] st8;
      bit           inv;
      int           lat;

      in_valid = 0; in_inverse = 0; in_state = '0; out_ready = 0;
      in_valid8 = 0; in_inverse8 = 0; in_state8 = '0; out_ready8 = 0;
      #1;
      check("reset_ready", in_ready, 1);
      check("reset_valid", out_valid, 0);
      check("reset_state", out_state, 0);
      check("reset_ready8", in_ready8, 1);
      check("reset_state8", out_state8, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run4(V29, 1'b0, 0, E29, "fwd_vec");
      run4(V29, 1'b0, 5, E29, "backpressure");
      e30 = INV_EN ? E30 : mix_model({128'b0, V30}, 4, 1'b0);
      run4(V30, 1'b1, 1, e30, "inv_vec");
      e34 = INV_EN ? mix_model({128'b0, V29}, 4, 1'b1) : E29;
      run4(V29, 1'b1, 0, e34, "inv_sel_vec");

      // Reset while column 2 is pending.
      in_valid = 1'b1; in_state = V29; in_inverse = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      check("partial_state", out_state, {E29[127:64], V29[63:0]});
      rst_n = 1'b0;
      #1;
      check("midreset_valid", out_valid, 0);
      check("midreset_ready", in_ready, 1);
      check("midreset_state", out_state, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("postreset_valid", out_valid, 0);
      end
      run4(V29, 1'b0, 0, E29, "after_reset");

      // Random vectors against the model.
      for (int n = 0; n < 20; n++) begin
         st = {$urandom, $urandom, $urandom, $urandom};
         inv = 1'($urandom_range(0, 1));
         run4(st, inv, $urandom_range(0, 3),
              mix_model({128'b0, st}, 4, inv && INV_EN), "random");
      end

      // NB=8: directed then random vector.
      for (int n = 0; n < 2; n++) begin
         st8 = (n == 0) ? {8{32'hd4d4d4d5}}
                        : {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
         in_valid8 = 1'b1; in_state8 = st8; in_inverse8 = 1'b0;
         @(negedge clk);
         in_valid8 = 1'b0;
         lat = 0;
         while (!out_valid8 && lat < 24) begin
            check("nb8_busy_ready", in_ready8, 0);
            @(negedge clk);
            lat++;
         end
         check("nb8_latency", lat, 8);
         check("nb8_done_ready", in_ready8, 0);
         if (n == 0) check("nb8_result", out_state8, {8{32'hd5d5d7d6}});
         else        check("nb8_random", out_state8, mix_model(st8, 8, 1'b0));
         out_ready8 = 1'b1;
         @(negedge clk);
         out_ready8 = 1'b0;
         check("nb8_release_ready", in_ready8, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rijndael_mixcolumns_iter.md
RIJNDAEL_MIXCOLUMNS_ITER -- requirements
Module: rijndael_mixcolumns_iter

Interface
REQ-001 SHALL have parameter NB, default 4, meaning state columns; legal values 4, 6, 8.
REQ-002 SHALL have derived localparam STATESIZE = 32*NB, meaning state width in bits.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  input state offered.
REQ-006 SHALL have port in_ready  output  1  block accepts input.
REQ-007 SHALL have port in_inverse  input  1  1 = InvMixColumns, 0 = MixColumns; sampled at accept.
REQ-008 SHALL have port in_state  input  STATESIZE  state; column i, row j byte at bits [STATESIZE-1-32i-8j -: 8].
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out_state  output  STATESIZE  result, same byte layout as in_state.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL assert in_ready only in IDLE; accept occurs on a clock edge with in_valid && in_ready.
REQ-014 On accept SHALL register in_state and mode, clear column counter, and go IDLE->BUSY.
REQ-015 In BUSY SHALL transform exactly one column per cycle, column 0 first, through one shared 4-byte column datapath.
REQ-016 Forward column result SHALL equal matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02] over GF(2^8), polynomial 0x11B.
REQ-017 Inverse column result SHALL equal matrix [0e 0b 0d 09; 09 0e 0b 0d; 0d 09 0e 0b; 0b 0d 09 0e] over GF(2^8).
REQ-018 Column counter SHALL be $clog2(NB) bits; after column NB-1 the FSM SHALL go BUSY->DONE without wrapping.
REQ-019 out_valid SHALL be asserted exactly in DONE; first out_valid occurs NB cycles after the accept edge.
REQ-020 out_state SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 In DONE with out_ready=1 SHALL return to IDLE; no input is accepted in that same cycle.
REQ-022 out_state SHALL be undefined-free: outside DONE it SHALL show the partially updated working register.
REQ-023 in_valid, in_state, in_inverse changes outside IDLE SHALL have no effect.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, counter 0, working register 0, mode 0: in_ready=1, out_valid=0, out_state=0.
REQ-025 Reset during BUSY or DONE SHALL discard the operation; no out_valid follows reset.

Configuration
REQ-026 Macro RIJNDAEL_INV_MIXCOLUMNS_EN SHALL gate inverse support.
REQ-027 With RIJNDAEL_INV_MIXCOLUMNS_EN defined, in_inverse SHALL select REQ-016 or REQ-017.
REQ-028 Without it, no inverse logic SHALL be built, in_inverse SHALL be ignored, and REQ-016 always applies.

Verification
REQ-029 NB=4, forward, columns db135345 f20a225c 01010101 c6c6c6c6 -> out_state 8e4da1bc 9fdc589d 01010101 c6c6c6c6, out_valid 4 cycles after accept.
REQ-030 NB=4, inverse (macro defined), columns 8e4da1bc 9fdc589d d5d5d7d6 4d7ebdf8 -> db135345 f20a225c d4d4d4d5 2d26314c.
REQ-031 NB=8, forward, all columns d4d4d4d5 -> all columns d5d5d7d6, out_valid 8 cycles after accept, in_ready=0 throughout.
REQ-032 Back-pressure: out_ready=0 for 5 cycles in DONE -> out_state stable, out_valid=1, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-033 rst_n pulsed low at BUSY column 2 -> out_valid=0, in_ready=1, out_state=0 immediately; next vector of REQ-029 yields correct result.
REQ-034 Macro undefined, in_inverse=1 with REQ-029 input -> forward result of REQ-029.
